sysid_checker: RTL and testbench

Avalon-MM master that reads the system ID slave's two words after reset or on request: address 0 is the ID, address 1 is the timestamp.
It compares both against build-time expected values and publishes pass/fail flags plus the captured words.
It sits between the sysid slave and the boot/reset controller. `id_ok` gates CPU release so a mismatched FPGA image never boots.

---
 rtl/sysid_checker_pkg.sv | 18 +
 rtl/sysid_checker_avm_read_port.sv | 62 ++++++
 rtl/sysid_checker.sv | 120 ++++++++++++
 tb/tb_sysid_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system ID checker.
package sysid_checker_pkg;

    // Width of the per-read waitrequest stall counter.
    localparam int STALL_W = 16;

    // Word selects on the sysid slave.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

endpackage

// File: rtl/sysid_checker_avm_read_port.sv
// Single-read Avalon-MM master port with a waitrequest stall timeout.
// An issue pulse launches a read; the port holds read/address until the
// slave accepts or the stall budget is spent. Issuing in the acceptance
// cycle chains the next read with no idle cycle in between.
module avm_read_port
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic issue,
    input  logic issue_addr,
    input  logic avm_waitrequest,
    output logic avm_read,
    output logic avm_address,
    output logic data_valid,
    output logic timeout
);

    // Stall count at which a still-stalled read is abandoned.
    localparam logic [STALL_W-1:0] LAST_STALL = STALL_W'(TIMEOUT - 1);

    logic               read_q, read_d;
    logic               addr_q, addr_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    // Handshake outcome and next state; acceptance takes priority over timeout.
    always_comb begin
        data_valid = read_q && !avm_waitrequest;
        timeout    = read_q && avm_waitrequest && (stall_q == LAST_STALL);
        read_d     = read_q;
        addr_d     = addr_q;
        stall_d    = stall_q;
        if (issue) begin
            read_d  = 1'b1;
            addr_d  = issue_addr;
            stall_d = '0;
        end else if (data_valid || timeout) begin
            read_d  = 1'b0;
        end else if (read_q && avm_waitrequest) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Registered strobe/address; reset drops the strobe immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            read_q  <= read_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid ID and timestamp words, compares them with the values
// this image was built against and publishes sticky pass/timeout flags.
// id_ok gates CPU release, so it is only set by a completed, matching check.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h65FC128E,
    parameter logic [31:0] EXPECTED_TS = 32'h00000000,
    parameter int          CHECK_TS    = 0,
    parameter int          TIMEOUT     = 255,
    parameter int          AUTO_START  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        timeout_err,
    output logic [31:0] sysid_value,
    output logic [31:0] sysid_timestamp
);

    state_t      state_q, state_d;
    logic        pend_q;
    logic        id_ok_q, tmo_err_q;
    logic [31:0] value_q, ts_q;
    logic        issue, issue_addr, leave_idle;
    logic        data_valid, rd_timeout;
    logic        match;

    avm_read_port #(.TIMEOUT(TIMEOUT)) u_port (
        .clock           (clock),
        .reset_n         (reset_n),
        .issue           (issue),
        .issue_addr      (issue_addr),
        .avm_waitrequest (avm_waitrequest),
        .avm_read        (avm_read),
        .avm_address     (avm_address),
        .data_valid      (data_valid),
        .timeout         (rd_timeout)
    );

    assign match = (value_q == EXPECTED_ID) &&
                   ((CHECK_TS == 0) || (ts_q == EXPECTED_TS));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Sequencing: ID read chains straight into the timestamp read.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = SYSID_ADDR_ID;
        leave_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || pend_q) begin
                    leave_idle = 1'b1;
                    issue      = 1'b1;
                    state_d    = RD_ID;
                end
            end
            RD_ID: begin
                if (data_valid) begin
                    issue      = 1'b1;
                    issue_addr = SYSID_ADDR_TS;
                    state_d    = RD_TS;
                end else if (rd_timeout) begin
                    state_d    = IDLE;
                end
            end
            RD_TS: begin
                if (data_valid)      state_d = CMP;
                else if (rd_timeout) state_d = IDLE;
            end
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Captured words and sticky result flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= (AUTO_START != 0);
            id_ok_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            value_q   <= '0;
            ts_q      <= '0;
        end else begin
            if (leave_idle) begin
                pend_q    <= 1'b0;
                id_ok_q   <= 1'b0;
                tmo_err_q <= 1'b0;
            end
            if (state_q == RD_ID && data_valid) value_q <= avm_readdata;
            if (state_q == RD_TS && data_valid) ts_q    <= avm_readdata;
            if (rd_timeout) begin
                tmo_err_q <= 1'b1;
                id_ok_q   <= 1'b0;
            end
            if (state_q == CMP) id_ok_q <= match;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == CMP) || rd_timeout;
    assign id_ok           = id_ok_q;
    assign timeout_err     = tmo_err_q;
    assign sysid_value     = value_q;
    assign sysid_timestamp = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: one instance with default compare settings and a
// short timeout, one with timestamp checking and no auto start, both served
// by a shared sysid slave model with programmable wait states.
module tb_sysid_checker;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    always #5 clock = ~clock;

    logic        a0, r0, busy0, done0, ok0, to0;
    logic        a1, r1, busy1, done1, ok1, to1;
    logic [31:0] v0, t0, v1, t1;

    // Slave model.
    logic [31:0] id_word = 32'h65FC128E, ts_word = 32'h5A5A0001;
    int          stall_n = 0;
    bit          stuck = 1'b0;
    int          scnt;
    logic        s_read, s_addr, s_wr;
    logic [31:0] s_data;
    assign s_read = r0 | r1;
    assign s_addr = r1 ? a1 : a0;
    assign s_wr   = s_read && (stuck || (scnt < stall_n));
    assign s_data = s_addr ? ts_word : id_word;
    always @(posedge clock or negedge reset_n)
        if (!reset_n)          scnt <= 0;
        else if (s_read && s_wr) scnt <= scnt + 1;
        else                   scnt <= 0;

    sysid_checker #(.TIMEOUT(8)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start0),
        .avm_address(a0), .avm_read(r0), .avm_readdata(s_data), .avm_waitrequest(s_wr),
        .busy(busy0), .done(done0), .id_ok(ok0), .timeout_err(to0),
        .sysid_value(v0), .sysid_timestamp(t0));

    sysid_checker #(.CHECK_TS(1), .EXPECTED_TS(32'h1), .TIMEOUT(8), .AUTO_START(0)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start1),
        .avm_address(a1), .avm_read(r1), .avm_readdata(s_data), .avm_waitrequest(s_wr),
        .busy(busy1), .done(done1), .id_ok(ok1), .timeout_err(to1),
        .sysid_value(v1), .sysid_timestamp(t1));

    typedef struct packed {
        logic        ok;
        logic        to;
        logic [31:0] v;
        logic [31:0] t;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    bit   unstable;
    logic rd_log [0:127];
    logic ad_log [0:127];

    // Waits for done on the chosen instance; k = cycle index after the
    // launching edge (-1 if it never came). Logs strobe/address per cycle and
    // flags any change of a stalled request.
    task automatic wait_done(input bit which, output int k);
        logic prd, pad, pwr, rd, ad, dn;
        prd = 1'b0; pad = 1'b0; pwr = 1'b0;
        unstable = 1'b0;
        k = -1;
        for (int i = 1; i < 120; i++) begin
            @(negedge clock);
            start0 = 1'b0; start1 = 1'b0;
            rd = which ? r1 : r0;
            ad = which ? a1 : a0;
            dn = which ? done1 : done0;
            rd_log[i] = rd; ad_log[i] = ad;
            if (prd && pwr && (!rd || ad != pad)) unstable = 1'b1;
            prd = rd; pad = ad; pwr = s_wr;
            if (dn) begin k = i; break; end
        end
    endtask

    task automatic test_reset;
        int k;
        exp_t e;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({r0, a0, busy0, done0, ok0, to0} !== 6'b0)
            begin errors++; $display("FAIL reset_ctl0: got %b want 000000", {r0, a0, busy0, done0, ok0, to0}); end
        checks++;
        if ({v0, t0} !== 64'b0)
            begin errors++; $display("FAIL reset_words0: got %h want 0", {v0, t0}); end
        checks++;
        if ({r1, a1, busy1, done1, ok1, to1} !== 6'b0 || {v1, t1} !== 64'b0)
            begin errors++; $display("FAIL reset_dut1: got %b %h want 0", {r1, a1, busy1, done1, ok1, to1}, {v1, t1}); end
        // Release: dut0 auto-starts on the first edge.
        reset_n = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        checks++;
        if (k !== 3) begin errors++; $display("FAIL auto_latency: got %0d want 3", k); end
        checks++;
        if (k == 3 && {rd_log[1], ad_log[1], rd_log[2], ad_log[2], rd_log[3]} !== 5'b10110)
            begin errors++; $display("FAIL auto_seq: got %b want 10110", {rd_log[1], ad_log[1], rd_log[2], ad_log[2], rd_log[3]}); end
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if ({ok0, to0, v0, t0} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL auto_result: got %b%b %h %h want %b%b %h %h", ok0, to0, v0, t0, e.ok, e.to, e.v, e.t); end
        checks++;
        if (busy1 !== 1'b0 || r1 !== 1'b0)
            begin errors++; $display("FAIL no_auto_dut1: got busy %b read %b want 0 0", busy1, r1); end
    endtask

    task automatic test_id_mismatch;
        int k;
        exp_t e;
        id_word = 32'h12345678;
        start0 = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h12345678, 32'h5A5A0001});
        wait_done(1'b0, k);
        checks++;
        if (k !== 3) begin errors++; $display("FAIL mismatch_latency: got %0d want 3", k); end
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if ({ok0, to0, v0, t0} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL mismatch_result: got %b%b %h %h want %b%b %h %h", ok0, to0, v0, t0, e.ok, e.to, e.v, e.t); end
        id_word = 32'h65FC128E;
    endtask

    task automatic test_wait_states(input int stalls);
        int k;
        exp_t e;
        stall_n = stalls;
        start0 = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        checks++;
        if (k !== 2 * (stalls + 1) + 1)
            begin errors++; $display("FAIL wait_latency_%0d: got %0d want %0d", stalls, k, 2 * (stalls + 1) + 1); end
        checks++;
        if (unstable) begin errors++; $display("FAIL wait_stable_%0d: got changed request want stable", stalls); end
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if ({ok0, to0, v0, t0} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL wait_result_%0d: got %b%b %h %h want %b%b %h %h", stalls, ok0, to0, v0, t0, e.ok, e.to, e.v, e.t); end
        stall_n = 0;
    endtask

    task automatic test_timeout;
        int k;
        exp_t e;
        stuck = 1'b1;
        id_word = 32'hDEADBEEF;
        start0 = 1'b1;
        // Nothing is read, so the previous captures must survive.
        sb.push_back('{1'b0, 1'b1, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        checks++;
        if (k !== 8) begin errors++; $display("FAIL timeout_latency: got %0d want 8", k); end
        @(negedge clock);
        checks++;
        if (r0 !== 1'b0 || busy0 !== 1'b0)
            begin errors++; $display("FAIL timeout_idle: got read %b busy %b want 0 0", r0, busy0); end
        e = sb.pop_front();
        checks++;
        if ({ok0, to0, v0, t0} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL timeout_result: got %b%b %h %h want %b%b %h %h", ok0, to0, v0, t0, e.ok, e.to, e.v, e.t); end
        stuck = 1'b0;
        id_word = 32'h65FC128E;
    endtask

    task automatic test_back_to_back;
        int k, extra;
        exp_t e;
        start0 = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        start0 = 1'b1;  // coincides with done: must be dropped
        @(negedge clock);
        start0 = 1'b0;
        e = sb.pop_front();
        checks++;
        if (k !== 3 || {ok0, to0} !== {e.ok, e.to})
            begin errors++; $display("FAIL b2b_first: got k=%0d %b%b want k=3 %b%b", k, ok0, to0, e.ok, e.to); end
        extra = 0;
        repeat (8) begin
            @(negedge clock);
            if (busy0 || done0) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL b2b_ignored: got %0d busy cycles want 0", extra); end
        start0 = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if (k !== 3 || {ok0, to0} !== {e.ok, e.to})
            begin errors++; $display("FAIL b2b_next: got k=%0d %b%b want k=3 %b%b", k, ok0, to0, e.ok, e.to); end
    endtask

    task automatic test_reset_mid;
        int k;
        bit seen;
        exp_t e;
        stall_n = 3;
        start0 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            start0 = 1'b0;
            if (r0 && a0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_mid_reach: got no RD_TS read want one"); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({r0, a0, busy0, done0, ok0, to0} !== 6'b0 || {v0, t0} !== 64'b0)
            begin errors++; $display("FAIL rst_mid_async: got %b %h want 0", {r0, a0, busy0, done0, ok0, to0}, {v0, t0}); end
        @(negedge clock);
        reset_n = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h5A5A0001});
        wait_done(1'b0, k);
        checks++;
        if (k !== 9) begin errors++; $display("FAIL rst_mid_rerun: got %0d want 9", k); end
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if ({ok0, to0, v0, t0} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL rst_mid_result: got %b%b %h %h want %b%b %h %h", ok0, to0, v0, t0, e.ok, e.to, e.v, e.t); end
        stall_n = 0;
    endtask

    task automatic test_check_ts_busy;
        int k, dones, first;
        exp_t e;
        stall_n = 2;
        ts_word = 32'h2;
        start1 = 1'b1;
        sb.push_back('{1'b0, 1'b0, 32'h65FC128E, 32'h2});
        dones = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            start1 = (i == 3);  // re-request while busy
            if (done1) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        start1 = 1'b0;
        checks++;
        if (dones !== 1 || first !== 7)
            begin errors++; $display("FAIL busy_start: got %0d dones first %0d want 1 first 7", dones, first); end
        e = sb.pop_front();
        checks++;
        if ({ok1, to1, v1, t1} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL ts_mismatch: got %b%b %h %h want %b%b %h %h", ok1, to1, v1, t1, e.ok, e.to, e.v, e.t); end
        // Matching timestamp passes on the timestamp-checking instance.
        stall_n = 0;
        ts_word = 32'h1;
        start1 = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h65FC128E, 32'h1});
        wait_done(1'b1, k);
        @(negedge clock);
        e = sb.pop_front();
        checks++;
        if (k !== 3 || {ok1, to1, v1, t1} !== {e.ok, e.to, e.v, e.t})
            begin errors++; $display("FAIL ts_match: got k=%0d %b%b %h want k=3 %b%b %h", k, ok1, to1, t1, e.ok, e.to, e.t); end
        ts_word = 32'h5A5A0001;
    endtask

    initial begin
        test_reset();
        test_id_mismatch();
        test_wait_states(5);
        test_wait_states(7);
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_check_ts_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
